// File: rtl/cpu_pkg.sv
// Shared CPU-core types for the instruction/data RAM port arbiter.
package cpu_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store requesters.
// MEM has priority unless the starvation guard has tripped while IF waits.
module mem_arb_pick (
  input  logic if_req,
  input  logic mem_req,
  input  logic starve_hit,
  output logic if_win,
  output logic mem_win
);

  // MEM wins unless IF is waiting and has been passed over too often
  always_comb begin
    mem_win = mem_req && (!if_req || !starve_hit);
    if_win  = if_req && !mem_win;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port instruction/data RAM between IF and MEM.
// Writes complete at the grant edge; reads hold the port for RD_LATENCY
// cycles and return data to the owner with a one-cycle rvalid pulse.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [1:0] LAT_LOAD   = 2'(RD_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t state_q;
  owner_t     owner_q;
  logic [1:0] lat_cnt_q;
  logic [3:0] starve_cnt_q;

  logic starve_hit;
  logic if_win;
  logic mem_win;
  logic in_idle;
  logic rd_fire;

  assign starve_hit = (starve_cnt_q >= STARVE_MAX);

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .mem_req    (mem_req),
    .starve_hit (starve_hit),
    .if_win     (if_win),
    .mem_win    (mem_win)
  );

  // Grant, RAM strobe and read return, all gated by reset and state
  always_comb begin
    in_idle    = reset_n && (state_q == IDLE);
    busy       = reset_n && (state_q == WAIT);
    if_gnt     = in_idle && if_win;
    mem_gnt    = in_idle && mem_win;
    ram_en     = if_gnt || mem_gnt;
    ram_we     = mem_gnt && mem_we;
    ram_addr   = mem_gnt ? mem_addr : (if_gnt ? if_addr : '0);
    ram_wdata  = mem_gnt ? mem_wdata : '0;
    rd_fire    = busy && (lat_cnt_q == 2'd0);
    if_rvalid  = rd_fire && (owner_q == OWNER_IF);
    mem_rvalid = rd_fire && (owner_q == OWNER_MEM);
    if_rdata   = if_rvalid ? ram_rdata : '0;
    mem_rdata  = mem_rvalid ? ram_rdata : '0;
  end

  // Read FSM: a read grant parks the port in WAIT until the data returns
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_IF;
      lat_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (ram_en && !ram_we) begin
        state_q   <= WAIT;
        owner_q   <= mem_gnt ? OWNER_MEM : OWNER_IF;
        lat_cnt_q <= LAT_LOAD;
      end
    end else if (lat_cnt_q == 2'd0) begin
      state_q <= IDLE;
    end else begin
      lat_cnt_q <= lat_cnt_q - 2'd1;
    end
  end

  // Count consecutive MEM wins over a waiting IF; any IF win or idle IF clears
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt_q <= '0;
    end else if (mem_gnt && !starve_hit) begin
      starve_cnt_q <= starve_cnt_q + 4'd1;
    end
  end

  a_param_range : assert property (@(posedge clk)
    (RD_LATENCY >= 1) && (RD_LATENCY <= 4) && (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15));

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    !(if_gnt && mem_gnt));

  a_no_gnt_busy : assert property (@(posedge clk) disable iff (!reset_n)
    busy |-> !(if_gnt || mem_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (RD_LATENCY 2 and 1)
// share the same stimulus; a cycle-level reference model queues expected
// grants and read returns, and a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  localparam int NI    = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] rd_val;

  logic        if_gnt_w     [NI];
  logic        if_rvalid_w  [NI];
  logic [31:0] if_rdata_w   [NI];
  logic        mem_gnt_w    [NI];
  logic        mem_rvalid_w [NI];
  logic [31:0] mem_rdata_w  [NI];
  logic        ram_en_w     [NI];
  logic        ram_we_w     [NI];
  logic [31:0] ram_addr_w   [NI];
  logic [31:0] ram_wdata_w  [NI];
  logic        busy_w       [NI];

  int lat_of [NI] = '{2, 1};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .RD_LATENCY   ((g == 0) ? 2 : 1),
      .STARVE_LIMIT (LIMIT)
    ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt_w[g]),
      .if_rvalid  (if_rvalid_w[g]),
      .if_rdata   (if_rdata_w[g]),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt_w[g]),
      .mem_rvalid (mem_rvalid_w[g]),
      .mem_rdata  (mem_rdata_w[g]),
      .ram_en     (ram_en_w[g]),
      .ram_we     (ram_we_w[g]),
      .ram_addr   (ram_addr_w[g]),
      .ram_wdata  (ram_wdata_w[g]),
      .ram_rdata  (rd_val),
      .busy       (busy_w[g])
    );
  end

  typedef struct {
    int          cyc;
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int cyc;
    bit is_mem;
  } ret_t;

  gnt_t gq [NI][$];
  ret_t rq [NI][$];
  int   free_c   [NI];
  int   starve   [NI];
  bit   exp_busy [NI];
  int   cyc;
  bit   run;
  int   n_chk;
  int   n_fail;

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  // Reference model: port is free once the previous read's data has returned
  task automatic model();
    for (int k = 0; k < NI; k++) begin
      bit   mw;
      bit   iw;
      gnt_t g;
      ret_t r;
      mw = 1'b0;
      iw = 1'b0;
      if (!reset_n) begin
        exp_busy[k] = 1'b0;
        free_c[k]   = cyc + 1;
        starve[k]   = 0;
        rq[k].delete();
      end else begin
        exp_busy[k] = (cyc < free_c[k]);
        if (!exp_busy[k]) begin
          mw = mem_req && (!if_req || (starve[k] < LIMIT));
          iw = if_req && !mw;
          if (mw || iw) begin
            g.cyc    = cyc;
            g.is_mem = mw;
            g.we     = mw && mem_we;
            g.addr   = mw ? mem_addr : if_addr;
            g.wdata  = mw ? mem_wdata : 32'h0;
            gq[k].push_back(g);
            if (!g.we) begin
              r.cyc    = cyc + lat_of[k];
              r.is_mem = mw;
              rq[k].push_back(r);
              free_c[k] = cyc + lat_of[k] + 1;
            end
          end
        end
        if (iw || !if_req) starve[k] = 0;
        else if (mw && starve[k] < LIMIT) starve[k] = starve[k] + 1;
      end
    end
  endtask

  task automatic step(input bit rn, input bit ir, input logic [31:0] ia,
                      input bit mr, input bit mwe, input logic [31:0] ma,
                      input logic [31:0] md, input logic [31:0] rd);
    reset_n   = rn;
    if_req    = ir;
    if_addr   = ia;
    mem_req   = mr;
    mem_we    = mwe;
    mem_addr  = ma;
    mem_wdata = md;
    rd_val    = rd;
    model();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, $urandom);
  endtask

  // Monitor: compare DUT outputs with the queued expectations each cycle
  always @(negedge clk) begin : monitor
    gnt_t g;
    ret_t r;
    bit   hg;
    bit   hr;
    if (run) begin
      for (int k = 0; k < NI; k++) begin
        hg = (gq[k].size() > 0) && (gq[k][0].cyc == cyc);
        g  = '{cyc: 0, is_mem: 0, we: 0, addr: 32'h0, wdata: 32'h0};
        if (hg) g = gq[k].pop_front();
        chk(k, "if_gnt",    32'(if_gnt_w[k]),  32'(hg && !g.is_mem));
        chk(k, "mem_gnt",   32'(mem_gnt_w[k]), 32'(hg && g.is_mem));
        chk(k, "ram_en",    32'(ram_en_w[k]),  32'(hg));
        chk(k, "ram_we",    32'(ram_we_w[k]),  32'(hg && g.we));
        chk(k, "ram_addr",  ram_addr_w[k],     g.addr);
        chk(k, "ram_wdata", ram_wdata_w[k],    g.wdata);

        hr = (rq[k].size() > 0) && (rq[k][0].cyc == cyc);
        r  = '{cyc: 0, is_mem: 0};
        if (hr) r = rq[k].pop_front();
        chk(k, "if_rvalid",  32'(if_rvalid_w[k]),  32'(hr && !r.is_mem));
        chk(k, "mem_rvalid", 32'(mem_rvalid_w[k]), 32'(hr && r.is_mem));
        chk(k, "if_rdata",   if_rdata_w[k],  (hr && !r.is_mem) ? rd_val : 32'h0);
        chk(k, "mem_rdata",  mem_rdata_w[k], (hr && r.is_mem) ? rd_val : 32'h0);
        chk(k, "busy",       32'(busy_w[k]),  32'(exp_busy[k]));
      end
    end
  end

  bit          r_ir;
  bit          r_mr;
  bit          r_we;
  bit          r_rn;
  logic [31:0] r_ia;
  logic [31:0] r_ma;
  logic [31:0] r_md;

  initial begin
    cyc    = 0;
    n_chk  = 0;
    n_fail = 0;
    for (int k = 0; k < NI; k++) begin
      free_c[k] = 0;
      starve[k] = 0;
    end
    run = 1'b1;

    // reset
    repeat (3) step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, $urandom);
    // single fetch at 0x10, data 0xDEADBEEF two cycles after grant
    step(1, 1, 32'h10, 0, 0, 32'h0, 32'h0, $urandom);
    step(1, 0, 32'h0,  0, 0, 32'h0, 32'h0, $urandom);
    step(1, 0, 32'h0,  0, 0, 32'h0, 32'h0, 32'hDEADBEEF);
    idle(3);
    // MEM write beats a simultaneous fetch
    step(1, 1, 32'h20, 1, 1, 32'h100, 32'h55, $urandom);
    step(1, 1, 32'h20, 0, 0, 32'h0,   32'h0,  $urandom);
    idle(5);
    // MEM reads held against a waiting fetch: starvation guard
    repeat (18) step(1, 1, 32'h40, 1, 0, 32'h200, 32'h0, $urandom);
    idle(5);
    // reset while a MEM read is in flight, fresh fetch right after
    step(1, 0, 32'h0,  1, 0, 32'h300, 32'h0, $urandom);
    step(0, 0, 32'h0,  0, 0, 32'h0,   32'h0, $urandom);
    step(1, 1, 32'h50, 0, 0, 32'h0,   32'h0, $urandom);
    idle(4);
    // back-to-back writes
    step(1, 0, 32'h0, 1, 1, 32'h0, 32'h11, $urandom);
    step(1, 0, 32'h0, 1, 1, 32'h4, 32'h22, $urandom);
    step(1, 0, 32'h0, 1, 1, 32'h8, 32'h33, $urandom);
    idle(2);
    // continuous fetch: grant spacing follows each instance's latency
    repeat (6) step(1, 1, 32'h60, 0, 0, 32'h0, 32'h0, $urandom);
    idle(4);

    // randomized traffic with occasional resets
    r_ir = 1'b0; r_mr = 1'b0; r_we = 1'b0;
    r_ia = 32'h0; r_ma = 32'h0; r_md = 32'h0;
    repeat (3000) begin
      if ($urandom_range(3) == 0) begin
        r_ir = 1'($urandom_range(1));
        r_ia = $urandom & 32'hFFFF_FFFC;
      end
      if ($urandom_range(3) == 0) begin
        r_mr = 1'($urandom_range(1));
        r_we = 1'($urandom_range(1));
        r_ma = $urandom & 32'hFFFF_FFFC;
        r_md = $urandom;
      end
      r_rn = ($urandom_range(49) != 0);
      step(r_rn, r_ir, r_ia, r_mr, r_we, r_ma, r_md, $urandom);
    end
    idle(8);
    run = 1'b0;

    for (int k = 0; k < NI; k++) begin
      chk(k, "grant_queue_drained",  32'(gq[k].size()), 32'h0);
      chk(k, "return_queue_drained", 32'(rq[k].size()), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port instruction/data RAM between the fetch requester (IF) and the load/store requester (MEM) of the CPU core. It accepts one request at a time over a req/gnt handshake and drives the RAM port. For reads, it waits a fixed RAM read latency and then returns the data to the owning requester with an rvalid pulse. MEM has priority over IF, with a starvation guard so fetch always makes progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LATENCY, 2, cycles from RAM issue to valid ram_rdata; legal range 1..4
STARVE_LIMIT, 4, consecutive MEM wins over a waiting IF before IF is forced to win; legal range 1..15

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
if_req  in  1  IF read request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  IF read address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  if_rdata valid (1-cycle pulse)
if_rdata  out  DATA_W  IF read data
mem_req  in  1  MEM request; held with addr/we/wdata stable until mem_gnt
mem_we  in  1  1 = write, 0 = read
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  MEM write data
mem_gnt  out  1  MEM request accepted this cycle
mem_rvalid  out  1  mem_rdata valid (1-cycle pulse; reads only)
mem_rdata  out  DATA_W  MEM read data
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid RD_LATENCY cycles after ram_en
busy  out  1  a read is in flight

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Outputs during and after reset: while reset_n=0, all outputs are 0. On the first cycle after release, state=IDLE and starve_cnt=0.
- States: IDLE, WAIT.
- IDLE arbitration:
  - Winner is MEM if mem_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT); otherwise IF if if_req=1; otherwise no grant.
  - Same cycle as the decision: winner's gnt=1, ram_en=1, ram_addr = winner's address; ram_we/ram_wdata from MEM when MEM wins, else 0.
  - Grant and RAM strobe are combinational from inputs and state, gated by reset_n.
- Write win: access completes at the grant edge. State stays IDLE, so the next grant can occur on the following cycle. No rvalid is generated.
- Read win: record owner, load lat_cnt=RD_LATENCY-1, go to WAIT.
- WAIT:
  - ram_en=0, both gnts=0, busy=1.
  - lat_cnt decrements each cycle.
  - When lat_cnt=0: owner's rvalid=1 and owner's rdata=ram_rdata, then next state IDLE.
  - Read grant-to-grant minimum is RD_LATENCY+1 cycles.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each MEM grant while if_req=1.
  - Clears on an IF grant, or on any cycle with if_req=0.
- Idle-output masking: rdata outputs are 0 when their rvalid=0. ram_addr/ram_wdata are 0 when ram_en=0.
- Requester rules: a requester deasserting req before gnt is legal; nothing is issued. A req already asserted during WAIT is not granted until IDLE.
- Reset mid-read: the in-flight read is dropped. No rvalid is ever produced for it, and late ram_rdata is ignored.
- Assertions: RD_LATENCY in range; gnt is one-hot; no gnt while busy.

Decomposition:
- Shared package (cpu_pkg): arb_state_t {IDLE, WAIT}; owner_t {OWNER_IF, OWNER_MEM}; default widths ADDR_W/DATA_W.
- Sub-module mem_arb_pick: the combinational winner selection (inputs if_req, mem_req, starve_hit; outputs if_win, mem_win).
- The FSM, latency counter and starvation counter stay in mem_port_arbiter.

Test Plan:
1. RD_LATENCY=2. Reset, then if_req addr 0x10 at cycle 0; RAM returns 0xDEADBEEF at cycle 2 -> if_gnt=1 and ram_addr=0x10 at cycle 0; if_rvalid=1 with if_rdata=0xDEADBEEF at cycle 2; busy cycles 1-2; mem_* outputs stay 0.
2. Cycle 0: if_req addr 0x20 and mem_req write addr 0x100 data 0x55 -> mem_gnt, ram_we=1, ram_addr=0x100, ram_wdata=0x55 at cycle 0; if_gnt with ram_addr=0x20 at cycle 1; if_rvalid at cycle 3.
3. mem_req read held continuously, if_req held, STARVE_LIMIT=4 -> MEM granted at cycles 0, 3, 6, 9; IF granted at cycle 12; MEM again at cycle 15.
4. MEM read granted at cycle 0; reset_n=0 at cycle 1, released at cycle 2 -> no mem_rvalid at any cycle; busy=0 from cycle 2; a fresh if_req at cycle 2 is granted at cycle 2.
5. Three back-to-back MEM writes to 0x0, 0x4, 0x8 -> mem_gnt at cycles 0, 1, 2; busy never set.
6. RD_LATENCY=1: IF read at cycle 0 -> if_rvalid at cycle 1; next IF grant at cycle 2.
